s_axi_write_ctrl: RTL and testbench

Parametrised AXI4-Lite write slave for the DFX sequencer register file, successor to the fixed bank0/bank1 write decoder. It accepts the AW and W channels independently in either order, decodes the address into a generic bank0-register or bank1-slot/field write pulse, and forwards byte strobes. Unmapped, disallowed and locked writes return SLVERR, and a saturating error counter tracks them. It sits between the PS AXI-Lite master and the bank0 control and bank1 slot-table storage.

---
 rtl/s_axi_write_ctrl_if.sv | 29 ++
 rtl/s_axi_write_ctrl.sv | 148 ++++++++++++++
 tb/tb_s_axi_write_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s_axi_write_ctrl_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the PS master and the
// sequencer register-file write slave.
interface s_axi_write_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

endinterface

// File: rtl/s_axi_write_ctrl.sv
// AXI4-Lite write slave for the DFX sequencer register file. Collects AW and W
// in any order, decodes into a bank0 register or bank1 slot/field write pulse,
// and answers OKAY or SLVERR with a saturating error count.
module s_axi_write_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned SLOT_INDEX_WIDTH = 3,
  parameter int unsigned FIELD_COUNT      = 6,
  parameter logic [15:0] BANK0_VALID_MASK = 16'h0039,
  parameter int unsigned ERR_CNT_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  s_axi_write_ctrl_if.slave           s_axi,
  input  logic                        wr_lock,
  output logic                        wr_bank0_en,
  output logic [3:0]                  wr_bank0_reg,
  output logic                        wr_bank1_en,
  output logic [SLOT_INDEX_WIDTH-1:0] wr_bank1_slot,
  output logic [3:0]                  wr_bank1_field,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH/8-1:0]     wr_strb,
  output logic [ERR_CNT_WIDTH-1:0]    err_cnt
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Address bits between the bank select and the decoded index must be zero.
  localparam logic [ADDR_WIDTH-1:0] BelowBankMask = {2'b00, {(ADDR_WIDTH-2){1'b1}}};
  localparam logic [ADDR_WIDTH-1:0] Bank0LowMask  = ADDR_WIDTH'(10'h3FF);
  localparam logic [ADDR_WIDTH-1:0] Bank1LowMask  =
      (ADDR_WIDTH'(1) << (SLOT_INDEX_WIDTH + 6)) - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] Bank0HiMask   = BelowBankMask & ~Bank0LowMask;
  localparam logic [ADDR_WIDTH-1:0] Bank1HiMask   = BelowBankMask & ~Bank1LowMask;

  typedef enum logic [1:0] {StCollect, StCommit, StResp} state_e;

  state_e                     state_q, state_d;
  logic                       aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [DATA_WIDTH/8-1:0]    strb_q;
  logic [1:0]                 resp_q;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q;

  logic       aw_ready, w_ready, b_valid;
  logic       aw_hs, w_hs;
  logic [1:0] bank;
  logic       bank0_ok, bank1_ok, dec_valid;
  logic       commit_err;

  assign aw_hs = s_axi.S_AXI_AWVALID & aw_ready;
  assign w_hs  = s_axi.S_AXI_WVALID & w_ready;

  // Address decode of the held write, evaluated while in StCommit.
  always_comb begin
    bank     = addr_q[ADDR_WIDTH-1 -: 2];
    bank0_ok = ((addr_q & Bank0HiMask) == '0) && BANK0_VALID_MASK[addr_q[9:6]];
    bank1_ok = ((addr_q & Bank1HiMask) == '0) && ({28'd0, addr_q[5:2]} < FIELD_COUNT) &&
               !wr_lock;
    unique case (bank)
      2'd0:    dec_valid = bank0_ok;
      2'd1:    dec_valid = bank1_ok;
      default: dec_valid = 1'b0;
    endcase
  end

  // Next-state logic plus handshake and write-pulse outputs.
  always_comb begin
    state_d     = state_q;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    wr_bank0_en = 1'b0;
    wr_bank1_en = 1'b0;
    commit_err  = 1'b0;
    unique case (state_q)
      StCollect: begin
        aw_ready = ~aw_held_q;
        w_ready  = ~w_held_q;
        if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) state_d = StCommit;
      end
      StCommit: begin
        state_d = StResp;
        if (!dec_valid) begin
          commit_err = 1'b1;
        end else if (strb_q != '0) begin
          wr_bank0_en = (bank == 2'd0);
          wr_bank1_en = (bank == 2'd1);
        end
      end
      StResp: begin
        b_valid = 1'b1;
        if (s_axi.S_AXI_BREADY) state_d = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StCollect;
    else       state_q <= state_d;
  end

  // Held AW/W payloads, response code and saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      resp_q    <= RespOkay;
      err_cnt_q <= '0;
    end else begin
      if (aw_hs) begin
        addr_q    <= s_axi.S_AXI_AWADDR;
        aw_held_q <= 1'b1;
      end
      if (w_hs) begin
        data_q   <= s_axi.S_AXI_WDATA;
        strb_q   <= s_axi.S_AXI_WSTRB;
        w_held_q <= 1'b1;
      end
      if (state_q == StCommit) resp_q <= dec_valid ? RespOkay : RespSlvErr;
      if (state_q == StResp && s_axi.S_AXI_BREADY) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (commit_err && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = b_valid ? resp_q : RespOkay;

  assign wr_bank0_reg   = addr_q[9:6];
  assign wr_bank1_slot  = addr_q[SLOT_INDEX_WIDTH+5:6];
  assign wr_bank1_field = addr_q[5:2];
  assign wr_data        = data_q;
  assign wr_strb        = strb_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_s_axi_write_ctrl.sv
// Directed bench for s_axi_write_ctrl: a vector table of single writes plus
// hand-written stall, reset-during-response and saturation sequences.
module tb_s_axi_write_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_lock;
  logic        wr_bank0_en;
  logic [3:0]  wr_bank0_reg;
  logic        wr_bank1_en;
  logic [2:0]  wr_bank1_slot;
  logic [3:0]  wr_bank1_field;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [7:0]  err_cnt;

  s_axi_write_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  s_axi_write_ctrl #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .SLOT_INDEX_WIDTH(3),
    .FIELD_COUNT     (6),
    .BANK0_VALID_MASK(16'h0039),
    .ERR_CNT_WIDTH   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi         (axi.slave),
    .wr_lock       (wr_lock),
    .wr_bank0_en   (wr_bank0_en),
    .wr_bank0_reg  (wr_bank0_reg),
    .wr_bank1_en   (wr_bank1_en),
    .wr_bank1_slot (wr_bank1_slot),
    .wr_bank1_field(wr_bank1_field),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        lock;
    int          aw_dly;
    int          w_dly;
    logic        exp_b0;
    logic        exp_b1;
    logic [3:0]  exp_idx;   // bank0 reg or bank1 field
    logic [2:0]  exp_slot;
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  localparam int NumVec = 16;
  vec_t vecs [NumVec];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err_cnt = 0;

  // Results of the most recent do_write.
  int          r_n_b0, r_n_b1, r_hs_cyc, r_pulse_cyc, r_bv_cyc, r_bv_cnt, r_bad_rdy;
  logic [3:0]  r_reg, r_field, r_strb;
  logic [2:0]  r_slot;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one write; entered and left just after a rising edge.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    int b_wait = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bit fin = 0;
    r_n_b0 = 0; r_n_b1 = 0; r_hs_cyc = -1; r_pulse_cyc = -1; r_bv_cyc = -1;
    r_bv_cnt = 0; r_bad_rdy = 0; r_resp = 2'bxx;
    r_reg = 'x; r_field = 'x; r_slot = 'x; r_data = 'x; r_strb = 'x;
    while (!fin && cyc < 60) begin
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_WDATA   = data;
      axi.S_AXI_WSTRB   = strb;
      axi.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      axi.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      axi.S_AXI_BREADY  = 1'b0;
      @(negedge clk);
      if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) begin aw_done = 1; r_hs_cyc = cyc; end
      if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) begin w_done = 1; r_hs_cyc = cyc; end
      if (wr_bank0_en) begin
        r_n_b0++;
        if (r_pulse_cyc < 0) r_pulse_cyc = cyc;
        r_reg = wr_bank0_reg; r_data = wr_data; r_strb = wr_strb;
      end
      if (wr_bank1_en) begin
        r_n_b1++;
        if (r_pulse_cyc < 0) r_pulse_cyc = cyc;
        r_slot = wr_bank1_slot; r_field = wr_bank1_field; r_data = wr_data; r_strb = wr_strb;
      end
      if (axi.S_AXI_BVALID) begin
        r_bv_cnt++;
        if (r_bv_cyc < 0) r_bv_cyc = cyc;
        r_resp = axi.S_AXI_BRESP;
        if (axi.S_AXI_AWREADY || axi.S_AXI_WREADY) r_bad_rdy++;
        if (b_wait == b_dly) begin
          axi.S_AXI_BREADY = 1'b1;
          fin = 1;
        end else begin
          b_wait++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    r_timeout = !fin;
  endtask

  task automatic bump_err();
    if (exp_err_cnt < 255) exp_err_cnt++;
  endtask

  initial begin
    // addr, data, strb, lock, aw_dly, w_dly, b0, b1, idx, slot, resp, err
    vecs[0]  = '{16'h0000, 32'h0000_0005, 4'hF, 1'b0, 0, 0, 1'b1, 1'b0, 4'd0, 3'd0, 2'b00, 1'b0};
    vecs[1]  = '{16'h4044, 32'h1000_0000, 4'hF, 1'b0, 3, 0, 1'b0, 1'b1, 4'd1, 3'd1, 2'b00, 1'b0};
    vecs[2]  = '{16'h4000, 32'h0000_0011, 4'hF, 1'b1, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[3]  = '{16'h0000, 32'h0000_0022, 4'hF, 1'b1, 0, 0, 1'b1, 1'b0, 4'd0, 3'd0, 2'b00, 1'b0};
    vecs[4]  = '{16'h0040, 32'h0000_0033, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[5]  = '{16'h4018, 32'h0000_0044, 4'hF, 1'b0, 0, 1, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[6]  = '{16'h8000, 32'h0000_0055, 4'hF, 1'b0, 1, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[7]  = '{16'h0100, 32'h0000_0066, 4'h0, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b00, 1'b0};
    vecs[8]  = '{16'h0143, 32'h0000_0077, 4'h3, 1'b0, 0, 2, 1'b1, 1'b0, 4'd5, 3'd0, 2'b00, 1'b0};
    vecs[9]  = '{16'h41D4, 32'hDEAD_BEEF, 4'hF, 1'b0, 1, 1, 1'b0, 1'b1, 4'd5, 3'd7, 2'b00, 1'b0};
    vecs[10] = '{16'h4200, 32'h0000_0088, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[11] = '{16'h0400, 32'h0000_0099, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[12] = '{16'hC000, 32'h0000_00AA, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};
    vecs[13] = '{16'h00C0, 32'h1234_5678, 4'h4, 1'b0, 2, 0, 1'b1, 1'b0, 4'd3, 3'd0, 2'b00, 1'b0};
    vecs[14] = '{16'h4010, 32'h0000_CAFE, 4'h8, 1'b0, 0, 0, 1'b0, 1'b1, 4'd4, 3'd0, 2'b00, 1'b0};
    vecs[15] = '{16'h0080, 32'h0000_00BB, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0, 4'd0, 3'd0, 2'b10, 1'b1};

    reset = 1'b1;
    wr_lock = 1'b0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(axi.S_AXI_AWREADY), 1);
    check("rst_wready", 32'(axi.S_AXI_WREADY), 1);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 0);
    check("rst_bresp", 32'(axi.S_AXI_BRESP), 0);
    check("rst_en", 32'({wr_bank0_en, wr_bank1_en}), 0);
    check("rst_data", wr_data, 0);
    check("rst_strb", 32'(wr_strb), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < NumVec; i++) begin
      wr_lock = vecs[i].lock;
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0);
      if (vecs[i].exp_err) bump_err();
      check($sformatf("v%0d_timeout", i), 32'(r_timeout), 0);
      check($sformatf("v%0d_b0_pulses", i), r_n_b0, 32'(vecs[i].exp_b0));
      check($sformatf("v%0d_b1_pulses", i), r_n_b1, 32'(vecs[i].exp_b1));
      check($sformatf("v%0d_bresp", i), 32'(r_resp), 32'(vecs[i].exp_resp));
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), exp_err_cnt);
      check($sformatf("v%0d_bvalid_lat", i), r_bv_cyc - r_hs_cyc, 2);
      if (vecs[i].exp_b0 || vecs[i].exp_b1) begin
        check($sformatf("v%0d_pulse_lat", i), r_pulse_cyc - r_hs_cyc, 1);
        check($sformatf("v%0d_data", i), r_data, vecs[i].data);
        check($sformatf("v%0d_strb", i), 32'(r_strb), 32'(vecs[i].strb));
      end
      if (vecs[i].exp_b0) check($sformatf("v%0d_reg", i), 32'(r_reg), 32'(vecs[i].exp_idx));
      if (vecs[i].exp_b1) begin
        check($sformatf("v%0d_field", i), 32'(r_field), 32'(vecs[i].exp_idx));
        check($sformatf("v%0d_slot", i), 32'(r_slot), 32'(vecs[i].exp_slot));
      end
    end
    wr_lock = 1'b0;

    // BREADY held low for 5 cycles: one pulse, BVALID stays up, no new acceptance.
    do_write(16'h0014, 32'h0000_00A5, 4'hF, 0, 0, 5);
    check("stall_b0_pulses", r_n_b0, 1);
    check("stall_bvalid_cycles", r_bv_cnt, 6);
    check("stall_ready_during_resp", r_bad_rdy, 0);
    check("stall_err_cnt", 32'(err_cnt), exp_err_cnt);
    @(negedge clk);
    check("ready_return_aw", 32'(axi.S_AXI_AWREADY), 1);
    check("ready_return_w", 32'(axi.S_AXI_WREADY), 1);
    @(posedge clk);
    #1;

    // Reset asserted while the SLVERR response is pending.
    axi.S_AXI_AWADDR = 16'h8000; axi.S_AXI_WDATA = 32'h1; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(posedge clk);
    #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    begin
      int w = 0;
      while (!axi.S_AXI_BVALID && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("rstresp_bvalid_seen", 32'(axi.S_AXI_BVALID), 1);
    end
    bump_err();
    check("rstresp_err_before", 32'(err_cnt), exp_err_cnt);
    reset = 1'b1;
    #1;
    check("rstresp_bvalid", 32'(axi.S_AXI_BVALID), 0);
    check("rstresp_err_cnt", 32'(err_cnt), 0);
    check("rstresp_awready", 32'(axi.S_AXI_AWREADY), 1);
    exp_err_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Error counter saturation.
    for (int n = 0; n < 300; n++) begin
      do_write(16'h8000, 32'(n), 4'hF, 0, 0, 0);
      bump_err();
      if (n == 253) check("sat_err_254", 32'(err_cnt), exp_err_cnt);
    end
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_bresp", 32'(r_resp), 2);
    check("sat_timeout", 32'(r_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
